spi_word_byte_fifo: RTL and testbench
=====================================

// Module: spi_word_byte_fifo
// PURPOSE
//   Downstream of spi_rx: buffers received SPI words (data_out/new_data_out) in a FIFO
//   and emits them one byte at a time on a valid/ready byte stream feeding the UART TX.
//   Absorbs rate mismatch between fast SPI word arrival and slow UART byte drain;
//   reports dropped words.
// PARAMETERS
//   DATA_WIDTH  16  received word width; must be a multiple of 8 (BYTES = DATA_WIDTH/8)
//   DEPTH       8   FIFO depth in words; power of two, >= 2
//   MSB_FIRST   1   1: most-significant byte emitted first; 0: least-significant first
// PORTS
//   clk_in          in   1                 system clock (100 MHz)
//   rst_in          in   1                 reset, asynchronous, active-low (0 = reset)
//   word_in         in   DATA_WIDTH        word from spi_rx data_out
//   word_valid_in   in   1                 one-cycle strobe from spi_rx new_data_out
//   byte_out        out  8                 current byte to UART TX
//   byte_valid_out  out  1                 byte_out valid
//   byte_ready_in   in   1                 consumer accepts byte when valid & ready
//   fill_out        out  $clog2(DEPTH+1)   words held in FIFO (excludes holding register)
//   empty_out       out  1                 FIFO empty AND serializer idle
//   overflow_out    out  1                 one-cycle pulse when an incoming word is dropped
// BEHAVIOUR
//   Reset (rst_in=0, async): byte_out=0, byte_valid_out=0, fill_out=0, empty_out=1,
//     overflow_out=0; FIFO pointers, byte index and holding register cleared; FSM -> IDLE.
//     Reset mid-transfer discards the partial word and all queued words; no byte emitted after release.
//   Write: word_valid_in=1 and FIFO not full -> word_in stored at tail, fill_out+1 next cycle.
//     Full and no pop this cycle -> word dropped, overflow_out=1 for exactly one cycle.
//     Full with pop in same cycle -> write accepted, fill_out unchanged, no overflow.
//   FSM states IDLE, SEND:
//     IDLE: FIFO not empty -> pop head into holding register, idx=0, go SEND.
//     SEND: byte_valid_out=1; byte_out = holding byte idx (MSB_FIRST selects order).
//       byte_out/byte_valid_out held stable while byte_ready_in=0.
//       valid&ready and idx<BYTES-1 -> idx+1.
//       valid&ready and idx=BYTES-1 -> FIFO not empty: pop next word, idx=0, stay SEND
//         (zero-bubble back-to-back); else -> IDLE, byte_valid_out=0 next cycle.
//   Latency: word sampled at edge N -> byte_valid_out high after edge N+1 (first byte).
//   Capacity: DEPTH words in FIFO plus one in holding register.
//   Pointers: $clog2(DEPTH) bits, wrap naturally; full/empty from count.
//   All outputs registered; empty_out = (count==0) && (state==IDLE).
// STRUCTURE
//   Package spi_uart_pkg: BYTE_W=8, typedef enum logic {IDLE, SEND} ser_state_t,
//     function bytes_per_word(DATA_WIDTH).
//   Sub-module sync_fifo #(WIDTH, DEPTH): single-clock FIFO with push/pop/full/empty/count,
//     same async active-low reset. Serializer FSM lives in this module.
// TESTING
//   1. Write 16'hBEE1, ready=1 -> byte_valid_out rises 2 edges after strobe;
//      bytes 8'hBE, 8'hE1 on consecutive cycles; then valid=0, empty_out=1.
//   2. Write 16'hBEE1, ready=0 for 5 cycles then 1 -> byte_out held 8'hBE with valid=1
//      throughout stall; then BE, E1 accepted.
//   3. Writes 16'hBEE1 and 16'hFEED 2 cycles apart, ready=1 -> stream BE E1 FE ED, no gap cycles.
//   4. ready=0, write 10 words (DEPTH=8) -> words 1-9 kept (1 in holding reg, fill_out=8),
//      10th dropped with single overflow_out pulse; release ready -> 18 bytes, in order.
//   5. FIFO full, write coincides with last-byte handshake -> write accepted, fill_out stays 8,
//      overflow_out=0.
//   6. Pull rst_in low after first byte of 16'hFEED, with 3 words queued -> byte_valid_out drops
//      without waiting for an edge, fill_out=0; after release, no bytes emitted.
//      Repeat test 1 with MSB_FIRST=0 -> E1 then BE.

Source files
------------

// File: rtl/spi_uart_pkg.sv
// spi_uart_pkg: shared byte width, serializer state type and word-to-byte helper
package spi_uart_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE, SEND} ser_state_t;
    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_W;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO, occupancy tracked by count
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/spi_word_byte_fifo.sv
// spi_word_byte_fifo: buffers SPI words and streams them out byte by byte on valid/ready
module spi_word_byte_fifo
    import spi_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [DATA_WIDTH-1:0]      word_in,
    input  logic                       word_valid_in,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid_out,
    input  logic                       byte_ready_in,
    output logic [$clog2(DEPTH+1)-1:0] fill_out,
    output logic                       empty_out,
    output logic                       overflow_out
);
    localparam int BYTES = bytes_per_word(DATA_WIDTH);
    localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    ser_state_t            state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt, fifo_dout;
    logic                  fifo_full, fifo_empty, push, pop;

    function automatic logic [BYTE_W-1:0] pick(input logic [DATA_WIDTH-1:0] w, input logic [IW-1:0] i);
        int k;
        k = MSB_FIRST ? BYTES - 1 - int'(i) : int'(i);
        return BYTE_W'(w >> (k * BYTE_W));
    endfunction

    // a pop in the same cycle frees the slot, so a full FIFO can still take the word
    assign push = word_valid_in && (!fifo_full || pop);

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push),
        .pop    (pop),
        .din    (word_in),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fill_out)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hold_nxt  = hold;
        pop       = 1'b0;
        if (state == IDLE || (byte_ready_in && idx == IW'(BYTES - 1))) begin
            pop       = !fifo_empty;
            state_nxt = fifo_empty ? IDLE : SEND;
            hold_nxt  = fifo_empty ? hold : fifo_dout;
            idx_nxt   = '0;
        end else if (byte_ready_in) begin
            idx_nxt = idx + 1'b1;
        end
    end

    // outputs are computed from next-state values so every one comes straight off a flop
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            idx            <= '0;
            hold           <= '0;
            byte_out       <= '0;
            byte_valid_out <= 1'b0;
            empty_out      <= 1'b1;
            overflow_out   <= 1'b0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            hold           <= hold_nxt;
            byte_out       <= pick(hold_nxt, idx_nxt);
            byte_valid_out <= state_nxt == SEND;
            empty_out      <= ((fill_out + CW'(push) - CW'(pop)) == '0) && (state_nxt == IDLE);
            overflow_out   <= word_valid_in && !push;
        end
    end
endmodule

// File: tb/tb_spi_word_byte_fifo.sv
// tb_spi_word_byte_fifo: queue-model and directed checks for both byte orders
module tb_spi_word_byte_fifo;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int NB = DW / 8;

    logic clk = 1'b0, rst_n = 1'b0, wv = 1'b0, ready = 1'b0;
    logic [DW-1:0] wi = '0;
    logic [7:0] bo, bo_l;
    logic bv, bv_l, emp, emp_l, ovf, ovf_l;
    logic [3:0] fill, fill_l;
    int passed = 0, total = 0, ovf_cnt = 0;

    logic [DW-1:0] q[$];
    logic [7:0] cm[$], cl[$], logm[$], logl[$];
    logic exp_ovf = 1'b0, m_hs, m_load, m_push;
    logic [DW-1:0] mw;
    logic [4:0] pat;

    always #5 clk = ~clk;

    spi_word_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
        .clk_in(clk), .rst_in(rst_n), .word_in(wi), .word_valid_in(wv),
        .byte_out(bo), .byte_valid_out(bv), .byte_ready_in(ready),
        .fill_out(fill), .empty_out(emp), .overflow_out(ovf)
    );

    spi_word_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
        .clk_in(clk), .rst_in(rst_n), .word_in(wi), .word_valid_in(wv),
        .byte_out(bo_l), .byte_valid_out(bv_l), .byte_ready_in(ready),
        .fill_out(fill_l), .empty_out(emp_l), .overflow_out(ovf_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] wgen(input int i);
        return 16'hA050 + 16'(i) * 16'h0101;
    endfunction

    // model: q holds words not yet started, cm/cl the remaining bytes of the word on the wire
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete(); cm.delete(); cl.delete();
            exp_ovf = 1'b0;
        end else begin
            if (bv && ready) logm.push_back(bo);
            if (bv_l && ready) logl.push_back(bo_l);
            m_hs = cm.size() > 0 && ready;
            m_load = q.size() > 0 && (cm.size() == 0 || (m_hs && cm.size() == 1));
            m_push = wv && (q.size() < DEPTH || m_load);
            exp_ovf = wv && !m_push;
            if (m_hs) begin
                void'(cm.pop_front());
                void'(cl.pop_front());
            end
            if (m_load) begin
                mw = q.pop_front();
                for (int b = 0; b < NB; b++) begin
                    cm.push_back(mw[(NB-1-b)*8 +: 8]);
                    cl.push_back(mw[b*8 +: 8]);
                end
            end
            if (m_push) q.push_back(wi);
        end
        #1;
        check("valid", bv, cm.size() > 0);
        check("valid_l", bv_l, cl.size() > 0);
        if (cm.size() > 0) check("byte", bo, cm[0]);
        if (cl.size() > 0) check("byte_l", bo_l, cl[0]);
        check("fill", fill, q.size());
        check("fill_l", fill_l, q.size());
        check("empty", emp, q.size() == 0 && cm.size() == 0);
        check("empty_l", emp_l, q.size() == 0 && cl.size() == 0);
        check("overflow", ovf, exp_ovf);
        check("overflow_l", ovf_l, exp_ovf);
        if (ovf) ovf_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [DW-1:0] w);
        wi = w;
        wv = 1'b1;
        tick();
        wv = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 200 && !emp; i++) tick();
        check("drain_done", emp, 1);
    endtask

    task automatic clear_logs();
        logm.delete();
        logl.delete();
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        clear_logs();
        ready = 1'b1;
        write(16'hBEE1);
        check("t1_lat_edge1", bv, 0);
        tick();
        check("t1_lat_edge2", bv, 1);
        check("t1_first", bo, 8'hBE);
        check("t1_first_lsb", bo_l, 8'hE1);
        tick();
        check("t1_second", bo, 8'hE1);
        tick();
        check("t1_idle", bv, 0);
        check("t1_empty", emp, 1);
        check("t1_count", logm.size(), 2);
        if (logm.size() == 2) check("t1_stream", {logm[0], logm[1]}, 16'hBEE1);
        if (logl.size() == 2) check("t1_stream_lsb", {logl[0], logl[1]}, 16'hE1BE);

        clear_logs();
        ready = 1'b0;
        write(16'hBEE1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", bv, 1);
            check("t2_stall_byte", bo, 8'hBE);
            tick();
        end
        drain();
        check("t2_count", logm.size(), 2);
        if (logm.size() == 2) check("t2_stream", {logm[0], logm[1]}, 16'hBEE1);

        clear_logs();
        ready = 1'b1;
        wi = 16'hBEE1;
        wv = 1'b1;
        tick();
        wi = 16'hFEED;
        tick();
        wv = 1'b0;
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            pat = {pat[3:0], bv};
            tick();
        end
        check("t3_no_gap", pat, 5'b11110);
        check("t3_count", logm.size(), 4);
        if (logm.size() == 4) check("t3_stream", {logm[0], logm[1], logm[2], logm[3]}, 32'hBEE1FEED);

        clear_logs();
        ready = 1'b0;
        ovf_cnt = 0;
        for (int i = 1; i <= 10; i++) write(wgen(i));
        tick();
        check("t4_fill", fill, 8);
        check("t4_ovf_pulses", ovf_cnt, 1);
        drain();
        check("t4_count", logm.size(), 18);
        if (logm.size() == 18)
            for (int i = 0; i < 9; i++) check("t4_word", {logm[2*i], logm[2*i+1]}, wgen(i + 1));

        clear_logs();
        ready = 1'b0;
        ovf_cnt = 0;
        for (int i = 1; i <= 9; i++) write(wgen(i));
        ready = 1'b1;
        tick();
        write(wgen(10));
        ready = 1'b0;
        check("t5_fill", fill, 8);
        check("t5_no_ovf", ovf_cnt, 0);
        check("t5_next_valid", bv, 1);
        drain();
        check("t5_count", logm.size(), 20);
        if (logm.size() == 20) check("t5_last", {logm[18], logm[19]}, wgen(10));

        clear_logs();
        ready = 1'b0;
        write(16'hFEED);
        write(wgen(1));
        write(wgen(2));
        write(wgen(3));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t6_pre_fill", fill, 3);
        check("t6_pre_byte", bo, 8'hED);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", bv, 0);
        check("t6_async_fill", fill, 0);
        check("t6_async_empty", emp, 1);
        tick(2);
        rst_n = 1'b1;
        clear_logs();
        ready = 1'b1;
        tick(10);
        check("t6_no_bytes", logm.size(), 0);
        check("t6_idle", bv, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end
endmodule
